// File: rtl/rr_stream_mux.sv
// -----------------------------------------------------------------------------
// rr_stream_mux
//
// Registered N-channel stream multiplexer feeding the ALU input stage.
// CHANNELS valid/ready input streams of WIDTH bits are funnelled into a single
// one-entry output register. The source is picked either by a round-robin
// arbiter (mode=0) or by a fixed channel index (mode=1).
//
// Optional feature macro: ARB_MUX_HOLD_EN
//   When defined, round-robin mode lets the current channel keep the grant for
//   up to MAX_BURST consecutive beats while its in_valid stays high. When not
//   defined, the grant rotates after every beat and no burst counter is built.
//
// Parameters:
//   WIDTH     - data width per channel (>= 1)
//   CHANNELS  - number of input channels (2..16)
//   MAX_BURST - max consecutive beats per channel (hold feature only, >= 1)
//   SELW      - channel index width, derived from CHANNELS
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - per-channel valid
//   in_data   - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_ready  - per-channel ready, one-hot or zero
//   mode      - 0 = round-robin, 1 = fixed select
//   sel       - channel used when mode=1
//   out_valid - output register holds a beat
//   out_data  - registered data
//   out_chan  - index of the channel that supplied out_data
//   out_ready - downstream accepts the beat
// -----------------------------------------------------------------------------
module rr_stream_mux #(
  parameter int  WIDTH     = 8,
  parameter int  CHANNELS  = 4,
  parameter int  MAX_BURST = 4,
  localparam int SELW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_bad_width
    $error("rr_stream_mux: WIDTH must be >= 1");
  end
  if ((CHANNELS < 2) || (CHANNELS > 16)) begin : g_bad_channels
    $error("rr_stream_mux: CHANNELS must be in 2..16");
  end
  if (MAX_BURST < 1) begin : g_bad_burst
    $error("rr_stream_mux: MAX_BURST must be >= 1");
  end

  // Round-robin search: first requester strictly after 'last', wrapping.
  // Returns {found, index}.
  function automatic logic [SELW:0] rr_pick(
    input logic [CHANNELS-1:0] req,
    input logic [SELW-1:0]     last
  );
    logic            found;
    logic [SELW-1:0] idx;
    int              cand;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand = int'(last) + off;
      cand = (cand >= CHANNELS) ? (cand - CHANNELS) : cand;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = SELW'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  // State
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0]     out_chan_q,  out_chan_d;
  logic [SELW-1:0]     last_grant_q, last_grant_d;

  // Combinational arbitration signals
  logic                can_load_s;
  logic                sel_in_range_s;
  logic [CHANNELS-1:0] elig_s;
  logic                hold_s;
  logic [SELW:0]       pick_s;
  logic                grant_any_s;
  logic [SELW-1:0]     grant_idx_s;
  logic [CHANNELS-1:0] grant_s;
  logic [WIDTH-1:0]    grant_data_s;
  logic                xfer_s;

  assign can_load_s     = !out_valid_q || out_ready;
  assign sel_in_range_s = (int'(sel) < CHANNELS);

  // Eligible set: every valid channel in round-robin, only sel in fixed mode.
  always_comb begin
    elig_s = '0;
    if (mode == 1'b0) begin
      elig_s = in_valid;
    end else if (sel_in_range_s) begin
      elig_s[sel] = in_valid[sel];
    end else begin
      elig_s = '0;
    end
  end

`ifdef ARB_MUX_HOLD_EN
  // Counter must reach MAX_BURST and be at least SELW bits.
  localparam int BURSTW = ($clog2(MAX_BURST + 1) > SELW) ? $clog2(MAX_BURST + 1) : SELW;

  logic [BURSTW-1:0] burst_cnt_q, burst_cnt_d;
  logic [BURSTW-1:0] burst_inc_s;

  // A nonzero count means the last granted channel is mid-burst; the count
  // wraps to zero on reaching MAX_BURST, which forces the next rotation.
  assign hold_s = (mode == 1'b0) && elig_s[last_grant_q] && (burst_cnt_q != '0);

  // Burst counter next state: restart on channel change, clear at the limit.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    burst_inc_s = '0;
    if (xfer_s) begin
      if (mode == 1'b1) begin
        burst_inc_s = '0;
      end else if (grant_idx_s != last_grant_q) begin
        burst_inc_s = BURSTW'(1);
      end else begin
        burst_inc_s = burst_cnt_q + BURSTW'(1);
      end
      burst_cnt_d = (burst_inc_s == BURSTW'(MAX_BURST)) ? '0 : burst_inc_s;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
  end

  // Burst counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign hold_s = 1'b0;
`endif

  assign pick_s = rr_pick(elig_s, last_grant_q);

  // Grant selection: keep the burst owner, otherwise take the round-robin pick.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    if (hold_s) begin
      grant_any_s = 1'b1;
      grant_idx_s = last_grant_q;
    end else begin
      grant_any_s = pick_s[SELW];
      grant_idx_s = pick_s[SELW-1:0];
    end
  end

  // One-hot grant vector and AND-OR data mux driven by it.
  always_comb begin
    grant_s      = '0;
    grant_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      grant_s[i]   = grant_any_s && (grant_idx_s == SELW'(i));
      grant_data_s = grant_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // in_ready is forced low during reset so no beat is accepted and lost.
  assign in_ready = grant_s & {CHANNELS{can_load_s && !rst}};
  assign xfer_s   = grant_any_s && can_load_s;

  // Output register and last-grant next state.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    last_grant_d = last_grant_q;
    if (xfer_s) begin
      // A load in the same cycle as a drain simply replaces the old beat.
      out_valid_d  = 1'b1;
      out_data_d   = grant_data_s;
      out_chan_d   = grant_idx_s;
      last_grant_d = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // Output register and last-grant state; last_grant resets so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      last_grant_q <= SELW'(CHANNELS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_stream_mux
//
// Directed bench for rr_stream_mux (WIDTH=8, CHANNELS=4, MAX_BURST=3).
// Stimulus pushes each expected output beat {chan, data} into a queue; a
// monitor on the falling edge pops and compares whenever a beat is accepted
// downstream (out_valid & out_ready). Timing-specific properties (reset,
// backpressure stability, in_ready patterns) are checked inline.
// -----------------------------------------------------------------------------
module tb_rr_stream_mux;
  localparam int WIDTH     = 8;
  localparam int CHANNELS  = 4;
  localparam int MAX_BURST = 3;
  localparam int SELW      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_ready;

  int checks   = 0;
  int failures = 0;
  logic [SELW+WIDTH-1:0] exp_q[$];

  rr_stream_mux #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mode     (mode),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SELW-1:0] ch, input logic [WIDTH-1:0] d);
    exp_q.push_back({ch, d});
  endtask

  // Scoreboard monitor: compare every accepted output beat.
  always @(negedge clk) begin : monitor
    logic [SELW+WIDTH-1:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_beat: got chan=%0d data=%0h expected no beat (t=%0t)",
                 out_chan, out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_chan", 32'(out_chan), 32'(e[SELW+WIDTH-1:WIDTH]));
        chk("beat_data", 32'(out_data), 32'(e[WIDTH-1:0]));
      end
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_chan",  32'(out_chan),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);

    // Round-robin fairness: 0,1,2,3,0 then 1 (held by backpressure below)
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rr_first_grant", 32'(in_ready), 32'h1);
    chk("rr_pre_valid",   32'(out_valid), 32'd0);
    push(2'd0, 8'h10); push(2'd1, 8'h21); push(2'd2, 8'h32);
    push(2'd3, 8'h43); push(2'd0, 8'h10); push(2'd1, 8'h21);
    tick();
    chk("rr_latency_valid", 32'(out_valid), 32'd1);
    chk("rr_latency_chan",  32'(out_chan),  32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_no_bubble", 32'(out_valid), 32'd1);
    end

    // Backpressure: ch1 beat 0x21 held for 3 cycles
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data",     32'(out_data), 32'h21);
      chk("bp_chan",     32'(out_chan), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h4);
    push(2'd2, 8'h32);
    tick();
    chk("bp_reload_chan", 32'(out_chan), 32'd2);
    chk("bp_reload_data", 32'(out_data), 32'h32);

    // Fixed mode sel=2
    mode = 1'b1;
    sel  = 2'd2;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fix_in_ready", 32'(in_ready), 32'h4);
      push(2'd2, 8'h32);
      tick();
      chk("fix_data", 32'(out_data), 32'h32);
    end
    in_valid = 4'b1011;
    #1;
    chk("fix_novalid_ready", 32'(in_ready), 32'd0);
    tick();
    chk("fix_drained_valid", 32'(out_valid), 32'd0);
    chk("fix_drained_data",  32'(out_data),  32'h32);

    // Reset mid-stream with a held beat
    mode      = 1'b0;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    tick();
    chk("mid_loaded_valid", 32'(out_valid), 32'd1);
    chk("mid_loaded_chan",  32'(out_chan),  32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",    32'(out_valid), 32'd0);
    chk("mid_rst_data",     32'(out_data),  32'd0);
    chk("mid_rst_chan",     32'(out_chan),  32'd0);
    chk("mid_rst_in_ready", 32'(in_ready),  32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h1);

    // Sparse round-robin from last_grant=3: 1,3,1,3
    in_valid = 4'b1010;
    #1;
    chk("sparse_first_grant", 32'(in_ready), 32'h2);
    push(2'd1, 8'h21); push(2'd3, 8'h43); push(2'd1, 8'h21); push(2'd3, 8'h43);
    for (int i = 0; i < 4; i++) tick();

    // Switch to fixed sel=3 mid-stream
    mode = 1'b1;
    sel  = 2'd3;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("switch_in_ready", 32'(in_ready), 32'h8);
      push(2'd3, 8'h43);
      tick();
    end
    in_valid = 4'b0000;
    mode     = 1'b0;
    tick();
    tick();

    // Burst hold test: ch1 and ch2 continuously valid after reset
    rst = 1'b1;
    #1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b0110;
`ifdef ARB_MUX_HOLD_EN
    push(2'd1, 8'h21); push(2'd1, 8'h21); push(2'd1, 8'h21);
    push(2'd2, 8'h32); push(2'd2, 8'h32); push(2'd2, 8'h32);
    push(2'd1, 8'h21);
`else
    push(2'd1, 8'h21); push(2'd2, 8'h32); push(2'd1, 8'h21);
    push(2'd2, 8'h32); push(2'd1, 8'h21); push(2'd2, 8'h32);
    push(2'd1, 8'h21);
`endif
    #1;
    for (int i = 0; i < 7; i++) tick();
    in_valid = 4'b0000;
    tick();
    tick();
    chk("final_drained", 32'(out_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Registered, parametrised N-channel stream multiplexer for the ALU datapath. It generalises the 4:1 bit-select mux to CHANNELS inputs of WIDTH bits each, with valid/ready handshakes on every port. Sources are chosen by a round-robin arbiter or by a fixed select. A one-entry output register sits between the operand sources and the ALU input stage.

## Interface
- WIDTH, 8: data width per channel (≥1)
- CHANNELS, 4: number of input channels (2..16)
- SELW, $clog2(CHANNELS): select/channel-index width (derived, not overridden)
- MAX_BURST, 4: max consecutive beats granted to one channel (used only with ARB_MUX_HOLD_EN; ≥1)

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  CHANNELS  per-channel valid
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  CHANNELS  per-channel ready (one-hot or zero)
- mode  input  1  0 = round-robin, 1 = fixed select
- sel  input  SELW  channel used when mode=1
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  registered data
- out_chan  output  SELW  index of channel that supplied out_data
- out_ready  input  1  downstream accepts beat

## Operation
- can_load = !out_valid | out_ready. A transfer on channel i happens when in_valid[i] & in_ready[i].
- Eligible set: mode=0 → all channels with in_valid; mode=1 → channel sel only, if in_valid[sel]. sel ≥ CHANNELS → no channel eligible.
- Round-robin: search starts at last_grant+1 and wraps modulo CHANNELS. The first eligible channel is granted.
- in_ready[i] = grant[i] & can_load & !rst. At most one bit is high. in_ready may depend on in_valid; sources must not make in_valid depend on in_ready.
- On transfer: out_data←in_data[i], out_chan←i, out_valid←1, last_grant←i. Applies in both modes.
- No transfer & out_ready & out_valid → out_valid←0. out_data and out_chan hold their values.
- Simultaneous drain and load in the same cycle → new beat replaces old. Sustained throughput is 1 beat/cycle.
- While out_valid & !out_ready: out_data and out_chan are stable and in_ready=0.
- A mode or sel change takes effect at the next arbitration cycle. The held output beat is unaffected.
- State: output register, last_grant (SELW), burst counter (SELW+ bits, macro only).

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1 (channel 0 wins first), burst count=0. in_ready=0 while rst is high.
- Reset mid-transfer: the held beat is discarded asynchronously. Arbitration restarts at channel 0 after release.
- Latency: input transfer at edge N → out_valid high after edge N, visible in cycle N+1.
- Arbitration is combinational. No bubble cycles under continuous out_ready=1.

## Configuration
- ARB_MUX_HOLD_EN defined: in mode=0, the current channel keeps the grant while in_valid stays high, up to MAX_BURST consecutive transfers. The counter increments per transfer and clears on a channel change or when it reaches MAX_BURST, which forces a rotation. A channel dropping in_valid releases the grant immediately. Mode=1 is unaffected.
- Not defined: the grant rotates after every transfer (strict per-beat round-robin). The burst counter is not built.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0 immediately. After release with all valid, first grant is channel 0.
- RR fairness (macro off, WIDTH=8): in_data ch0..3 = 0x10,0x21,0x32,0x43, all valid, out_ready=1 → out_chan sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle, first out_valid one cycle after first transfer.
- Backpressure: out_ready=0 for 3 cycles holding 0x21 → out_data=0x21, out_chan=1 stable, in_ready=0. out_ready=1 → next beat (ch2, 0x32) loaded the same edge with no bubble.
- Fixed mode: mode=1, sel=2, all valid → only in_ready[2] toggles and out_data stays 0x32 each beat. sel=2 with in_valid[2]=0 → no transfer, out_valid drops after drain.
- Sparse RR: only ch1 and ch3 valid, last_grant=3 → grants 1,3,1,3. Mode switch 0→1 (sel=3) mid-stream → from next cycle only ch3 is granted.
- Hold (ARB_MUX_HOLD_EN, MAX_BURST=3): ch1 and ch2 continuously valid → out_chan 1,1,1,2,2,2,1. The same stimulus without the macro → 1,2,1,2.
